// File: rtl/mxreg_write_arbiter_pkg.sv
// mx_regs_pkg: MX register bank load addresses, FLAGS slot and write request type
package mx_regs_pkg;
    localparam int MX_WL = 8;
    localparam logic [7:0] LD_A     = 8'h00;
    localparam logic [7:0] LD_B     = 8'h01;
    localparam logic [7:0] LD_C     = 8'h02;
    localparam logic [7:0] LD_D     = 8'h03;
    localparam logic [7:0] LD_R0    = 8'h0C;
    localparam logic [7:0] LD_R1    = 8'h0D;
    localparam logic [7:0] LD_R2    = 8'h0E;
    localparam logic [7:0] LD_R3    = 8'h0F;
    localparam logic [7:0] FLAGS_A  = 8'h10;
    localparam logic [7:0] FLAGS_D  = 8'h11;
    localparam logic [7:0] ADDR_MAX = 8'h11;
    localparam int FLAGS_IDX = 7;
    typedef struct packed {
        logic [7:0]       addr;
        logic [MX_WL-1:0] data;
        logic [MX_WL-1:0] flags;
    } mx_wr_req_t;
    function automatic logic is_flags_addr(input logic [7:0] a);
        return a == FLAGS_A || a == FLAGS_D;
    endfunction
endpackage

// File: rtl/mxreg_write_arbiter_if.sv
// mxreg_write_arbiter_if: requester side and bank write-port side of the MX write arbiter
interface mxreg_write_arbiter_if #(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH = 16,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]                  req;
    logic [NREQ-1:0][7:0]             req_addr;
    logic [NREQ-1:0][WORD_LENGTH-1:0] req_data;
    logic [NREQ-1:0][WORD_LENGTH-1:0] req_flags;
    logic [NREQ-1:0]                  gnt;
    logic                             hold;
    logic [7:0]                       load_addr;
    logic                             load_en;
    logic [DEPTH-1:0][WORD_LENGTH-1:0] data_line;
    logic                             err;
    modport master(output req, req_addr, req_data, req_flags, hold,
                   input gnt, load_addr, load_en, data_line, err);
    modport slave(input req, req_addr, req_data, req_flags, hold,
                  output gnt, load_addr, load_en, data_line, err);
endinterface

// File: rtl/mxreg_write_arbiter_rr_arbiter.sv
// mx_rr_arbiter: round-robin one-hot grant; pointer moves past the winner on each transfer
module mx_rr_arbiter #(
    parameter int N = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N-1:0]                   req,
    input  logic                           advance,
    input  logic                           hold,
    output logic [N-1:0]                   gnt,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] win
);
    localparam int W = N > 1 ? $clog2(N) : 1;
    logic [W-1:0] ptr;
    logic [W-1:0] cand;
    logic found;
    always_comb begin
        found = 1'b0;
        win = '0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
        gnt = (hold || rst || !found) ? '0 : N'(1) << win;
    end
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (advance) ptr <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
endmodule

// File: rtl/mxreg_write_arbiter.sv
// mxreg_write_arbiter: round-robin sharing of the MX bank write port with a registered write stage
module mxreg_write_arbiter
    import mx_regs_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int DEPTH = 16,
    parameter int NREQ = 4
) (
    input logic clk,
    input logic rst,
    mxreg_write_arbiter_if.slave bus
);
    localparam int W = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [NREQ-1:0] gnt;
    logic [W-1:0] win;
    logic xfer;
    logic load_en, err;
    logic [7:0] load_addr;
    logic [WORD_LENGTH-1:0] wr_data, wr_flags;
    logic [DEPTH-1:0][WORD_LENGTH-1:0] data_line;
    mx_rr_arbiter #(.N(NREQ)) u_arb (
        .clk(clk), .rst(rst), .req(bus.req), .advance(xfer),
        .hold(bus.hold), .gnt(gnt), .win(win)
    );
    assign xfer = |(bus.req & gnt);
    always_ff @(posedge clk) begin
        if (rst) begin
            load_en <= 1'b0;
            load_addr <= '0;
            wr_data <= '0;
            wr_flags <= '0;
            err <= 1'b0;
        end else begin
            load_en <= xfer;
            if (xfer) begin
                load_addr <= bus.req_addr[win];
                wr_data <= bus.req_data[win];
                wr_flags <= bus.req_flags[win];
                err <= err | (bus.req_addr[win] > ADDR_MAX);
            end
        end
    end
    // Only the FLAGS slot differs, and only for the two flag-loading addresses
    always_comb begin
        data_line = '0;
        for (int k = 0; k < DEPTH; k++)
            data_line[k] = (k == FLAGS_IDX && is_flags_addr(load_addr)) ? wr_flags : wr_data;
    end
    assign bus.gnt = gnt;
    assign bus.load_en = load_en;
    assign bus.load_addr = load_addr;
    assign bus.data_line = data_line;
    assign bus.err = err;
endmodule
